exibe_sequencia: RTL

Sequence-presentation engine for the memory game. It reads the stored sequence from the 16x4 synchronous game RAM, address 0 through the current round, and drives each stored 4-bit pattern onto the LEDs for a programmable on-time followed by a dark gap. It is the read/display side of the play datapath, which writes and compares player moves. It owns the RAM address while `ocupado` is high and signals completion with a one-cycle `pronto` pulse for the game control unit.

---
 rtl/exibe_sequencia_if.sv | 23 ++
 rtl/exibe_sequencia.sv | 120 ++++++++++++
 2 files changed

// File: rtl/exibe_sequencia_if.sv
// Bus between the sequence-presentation engine, the game RAM and the control unit.
// slave is the engine's view; master is the view of whoever drives and observes it.
interface exibe_sequencia_if;
    logic       iniciar;
    logic       parar;
    logic [3:0] rodada;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar, parar, rodada, dado,
        output endereco, leds, ocupado, pronto, db_estado
    );

    modport master (
        output iniciar, parar, rodada, dado,
        input  endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/exibe_sequencia.sv
// Plays the stored sequence from RAM address 0 through the latched round on the LEDs,
// each pattern lit for T_ACESO cycles followed by a T_APAGADO-cycle dark gap.
module exibe_sequencia #(
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250
) (
    input  logic               clock,
    input  logic               reset,
    exibe_sequencia_if.slave   bus
);
    localparam int TMAX0 = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TMAX  = (TMAX0 > 2) ? TMAX0 : 2;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        BUSCA   = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_e;

    estado_e        estado_q, estado_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     rodada_q, rodada_d;
    logic [3:0]     endereco_q, endereco_d;
    logic [3:0]     leds_q, leds_d;
    logic           pronto_q, pronto_d;
    logic           ocupado_q, ocupado_d;
    logic           aborta_s;

    assign aborta_s = bus.parar && (estado_q != INICIAL);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            timer_q    <= {TW{1'b0}};
            rodada_q   <= 4'h0;
            endereco_q <= 4'h0;
            leds_q     <= 4'h0;
            pronto_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            pronto_q   <= pronto_d;
            ocupado_q  <= ocupado_d;
        end
    end

    // Next-state logic; an abort overrides every transition, including the one into FIM.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: if (bus.iniciar) estado_d = BUSCA;   else estado_d = INICIAL;
            BUSCA:   if (timer_q == TW'(1)) estado_d = ACENDE; else estado_d = BUSCA;
            ACENDE:  if (timer_q == TW'(T_ACESO - 1)) estado_d = APAGA; else estado_d = ACENDE;
            APAGA:   if (timer_q == TW'(T_APAGADO - 1)) estado_d = PROXIMO; else estado_d = APAGA;
            PROXIMO: if (endereco_q == rodada_q) estado_d = FIM; else estado_d = BUSCA;
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
        if (aborta_s) begin
            estado_d = INICIAL;
        end else begin
            estado_d = estado_d;
        end
    end

    // Output and datapath next values, decided from the current state and the chosen transition.
    always_comb begin
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        case (estado_q)
            INICIAL: begin
                if (estado_d == BUSCA) begin
                    rodada_d   = bus.rodada;
                    endereco_d = 4'h0;
                    leds_d     = 4'h0;
                end else begin
                    leds_d = 4'h0;
                end
            end
            BUSCA:   if (estado_d == ACENDE) leds_d = bus.dado; else leds_d = 4'h0;
            ACENDE:  if (estado_d == APAGA) leds_d = 4'h0; else leds_d = leds_q;
            APAGA:   leds_d = 4'h0;
            PROXIMO: if (estado_d == BUSCA) endereco_d = endereco_q + 4'h1; else endereco_d = endereco_q;
            FIM:     leds_d = 4'h0;
            default: leds_d = 4'h0;
        endcase
        if (aborta_s) begin
            endereco_d = 4'h0;
            leds_d     = 4'h0;
        end else begin
            endereco_d = endereco_d;
        end

        // The timer restarts whenever the state changes, so each state counts from zero.
        if ((estado_d != estado_q) || (estado_q == INICIAL)) begin
            timer_d = {TW{1'b0}};
        end else begin
            timer_d = timer_q + TW'(1);
        end

        pronto_d  = (estado_d == FIM);
        ocupado_d = (estado_d != INICIAL);
    end

    assign bus.endereco  = endereco_q;
    assign bus.leds      = leds_q;
    assign bus.pronto    = pronto_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.db_estado = estado_q;
endmodule
